// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a valid/ready request/response handshake.
// Holds one request at a time. The response is presented LATENCY edges after
// acceptance, and the acceptance edge counts as the first of those edges.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | request latched, counting down the access latency
//   RESP  | response held on resp_* until the initiator consumes it
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic            accept, go_resp;
   logic            req_err;
   logic [AW-1:0]   req_idx;
   logic            lat_write, lat_err;
   logic [AW-1:0]   lat_idx;
   logic            sel_direct, rd_write, rd_err;
   logic [AW-1:0]   rd_idx;
   logic [31:0]     mem [DEPTH_WORDS];

   // req_ready is also gated by reset so nothing is accepted while held in reset
   assign req_ready  = (state == IDLE) && reset_n;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state == RESP);

   assign req_idx = req_addr[AW+1:2];
   assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));

   // With LATENCY=1 the response is built on the acceptance edge itself,
   // so the live request fields are used instead of the latched copy
   assign sel_direct = (state == IDLE);
   assign rd_idx     = sel_direct ? req_idx   : lat_idx;
   assign rd_write   = sel_direct ? req_write : lat_write;
   assign rd_err     = sel_direct ? req_err   : lat_err;

   // Next-state and countdown logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      go_resp   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nxt = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  go_resp   = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt <= 4'd1) begin
               cnt_nxt   = 4'd0;
               state_nxt = RESP;
               go_resp   = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, request latch and registered response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         lat_write  <= 1'b0;
         lat_err    <= 1'b0;
         lat_idx    <= '0;
         resp_rdata <= 32'd0;
         resp_error <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_idx;
         end
         if (go_resp) begin
            resp_error <= rd_err;
            resp_rdata <= (!rd_write && !rd_err) ? mem[rd_idx] : 32'd0;
         end
      end
   end

   // Stores commit on the acceptance edge; memory is never cleared by reset
   always_ff @(posedge clk) begin
      if (accept && req_write && !req_err) mem[req_idx] <= req_wdata;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=1.
// Directed vector table, hand-written reset/abort sequences and randomized
// traffic checked against an array-based memory model.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        resp_valid[2];
   logic        resp_ready[2];
   logic [31:0] resp_rdata[2];
   logic        resp_error[2];

   int n_cmp = 0;
   int n_bad = 0;
   int lat_of [2] = '{2, 1};

   logic [31:0] ref_mem [2][256];
   bit          ref_wr  [2][256];

   typedef struct {
      int          d;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          hold;
      bit          intrude;
   } vec_t;
   vec_t tbl [$];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One full transaction: present, measure latency, check, hold, consume.
   task automatic txn(int d, bit wr, logic [31:0] addr, logic [31:0] wdata,
                      logic [31:0] exp_rdata, bit exp_err, bit chk_rdata,
                      int hold, bit intrude, string tag);
      int          edges;
      logic [31:0] r0;
      logic        e0;
      @(negedge clk);
      edges = 0;
      while (!req_ready[d] && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      chk({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      resp_ready[d] = 1'b0;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      req_addr[d]  = $urandom;
      edges = 1;
      while (!resp_valid[d] && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({tag, " latency"}, 32'(edges), 32'(lat_of[d]));
      chk({tag, " error"}, 32'(resp_error[d]), 32'(exp_err));
      if (chk_rdata) chk({tag, " rdata"}, resp_rdata[d], exp_rdata);
      r0 = resp_rdata[d];
      e0 = resp_error[d];
      if (intrude) begin
         req_valid[d] = 1'b1;
         req_write[d] = 1'b1;
         req_addr[d]  = 32'h10;
         req_wdata[d] = 32'hBAD0_0BAD;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, " hold valid"}, 32'(resp_valid[d]), 32'd1);
         chk({tag, " hold rdata"}, resp_rdata[d], r0);
         chk({tag, " hold error"}, 32'(resp_error[d]), 32'(e0));
         chk({tag, " hold req_ready"}, 32'(req_ready[d]), 32'd0);
      end
      @(negedge clk);
      req_valid[d]  = 1'b0;
      chk({tag, " req_ready before consume"}, 32'(req_ready[d]), 32'd0);
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      resp_ready[d] = 1'b0;
      chk({tag, " valid after consume"}, 32'(resp_valid[d]), 32'd0);
      chk({tag, " req_ready after consume"}, 32'(req_ready[d]), 32'd1);
   endtask

   task automatic model_store(int d, bit wr, logic [31:0] addr, logic [31:0] wdata);
      if (wr && addr[1:0] == 2'b00 && (addr >> 2) < 256) begin
         ref_mem[d][addr[9:2]] = wdata;
         ref_wr[d][addr[9:2]]  = 1'b1;
      end
   endtask

   task automatic model_txn(int d, bit wr, logic [31:0] addr, logic [31:0] wdata,
                            int hold, string tag);
      bit          err;
      logic [31:0] exp;
      bit          known;
      err   = (addr % 4 != 0) || (addr / 4 >= 256);
      exp   = 32'd0;
      known = 1'b1;
      if (!wr && !err) begin
         exp   = ref_mem[d][addr[9:2]];
         known = ref_wr[d][addr[9:2]];
      end
      txn(d, wr, addr, wdata, exp, err, known, hold, 1'b0, tag);
      model_store(d, wr, addr, wdata);
   endtask

   // Accept a request on instance 0, then pull reset one cycle later.
   task automatic abort_txn(bit wr, logic [31:0] addr, logic [31:0] wdata, string tag);
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_write[0] = wr;
      req_addr[0]  = addr;
      req_wdata[0] = wdata;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk({tag, " accepted"}, 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk({tag, " req_ready in reset"}, 32'(req_ready[0]), 32'd0);
      chk({tag, " valid in reset"}, 32'(resp_valid[0]), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk({tag, " no response"}, 32'(resp_valid[0]), 32'd0);
         chk({tag, " req_ready after release"}, 32'(req_ready[0]), 32'd1);
      end
      model_store(0, wr, addr, wdata);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_valid[d]  = 1'b0;
         req_write[d]  = 1'b0;
         req_addr[d]   = 32'd0;
         req_wdata[d]  = 32'd0;
         resp_ready[d] = 1'b0;
         for (int i = 0; i < 256; i++) begin
            ref_mem[d][i] = 32'd0;
            ref_wr[d][i]  = 1'b0;
         end
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd0);
         chk($sformatf("reset resp_valid d%0d", d), 32'(resp_valid[d]), 32'd0);
         chk($sformatf("reset rdata d%0d", d), resp_rdata[d], 32'd0);
         chk($sformatf("reset error d%0d", d), 32'(resp_error[d]), 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
         chk($sformatf("post-reset req_ready d%0d", d), 32'(req_ready[d]), 32'd1);

      //            d  wr  addr           wdata          exp_rdata      err hold intr
      tbl.push_back('{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0,  0,   0});
      tbl.push_back('{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0,  0,   0});
      tbl.push_back('{0, 0, 32'h0000_0013, 32'h0,         32'h0,         1,  0,   0});
      tbl.push_back('{0, 1, 32'h0000_0013, 32'hCAFE_F00D, 32'h0,         1,  0,   0});
      tbl.push_back('{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0,  0,   0});
      tbl.push_back('{0, 0, 32'h0000_0400, 32'h0,         32'h0,         1,  0,   0});
      tbl.push_back('{0, 1, 32'h0000_03FC, 32'h1234_5678, 32'h0,         0,  0,   0});
      tbl.push_back('{0, 0, 32'h0000_03FC, 32'h0,         32'h1234_5678, 0,  0,   0});
      tbl.push_back('{0, 1, 32'h8000_0010, 32'h5555_AAAA, 32'h0,         1,  0,   0});
      tbl.push_back('{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0,  5,   1});
      tbl.push_back('{0, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0,  0,   0});
      tbl.push_back('{0, 1, 32'h0000_0014, 32'h1111_2222, 32'h0,         0,  2,   0});
      tbl.push_back('{0, 0, 32'h0000_0014, 32'h0,         32'h1111_2222, 0,  0,   0});
      tbl.push_back('{1, 1, 32'h0000_0000, 32'h0000_0001, 32'h0,         0,  0,   0});
      tbl.push_back('{1, 0, 32'h0000_0000, 32'h0,         32'h0000_0001, 0,  0,   0});
      tbl.push_back('{1, 0, 32'h0000_0002, 32'h0,         32'h0,         1,  3,   0});
      tbl.push_back('{1, 0, 32'h0000_0400, 32'h0,         32'h0,         1,  0,   0});

      for (int i = 0; i < tbl.size(); i++) begin
         txn(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
             tbl[i].exp_err, 1'b1, tbl[i].hold, tbl[i].intrude, $sformatf("vec%0d", i));
         model_store(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      end

      // reset during an in-flight store keeps the committed word; reset during a load drops it
      abort_txn(1'b1, 32'h0000_0024, 32'h5A5A_0024, "abort store");
      abort_txn(1'b0, 32'h0000_0010, 32'h0,         "abort load");
      txn(0, 1'b0, 32'h0000_0024, 32'h0, 32'h5A5A_0024, 1'b0, 1'b1, 0, 1'b0, "after abort 24");
      txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 1'b0, "after abort 10");

      for (int n = 0; n < 210; n++) begin
         int          d;
         int          r;
         bit          wr;
         logic [31:0] addr;
         d  = (n < 150) ? 0 : 1;
         wr = 1'($urandom_range(0, 1));
         r  = $urandom_range(0, 9);
         if (r == 0)
            addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else if (r == 1)
            addr = 32'((256 + $urandom_range(0, 4000)) * 4);
         else
            addr = 32'($urandom_range(0, 15) * 4);
         model_txn(d, wr, addr, $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 2, clock edges from request acceptance to response valid (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  initiator consumes response.
REQ-012 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port resp_error  output  1  request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-015 SHALL drive req_ready=1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-016 SHALL, on acceptance, latch req_write, req_addr, req_wdata, load wait counter with LATENCY-1, and go to WAIT (or to RESP directly when LATENCY=1).
REQ-017 SHALL, in WAIT, decrement the counter each edge and go to RESP on the edge where counter is 0; resp_valid first high exactly LATENCY edges after acceptance.
REQ-018 SHALL flag an error when addr[1:0]!=0 or word index addr[31:2] >= DEPTH_WORDS.
REQ-019 SHALL commit a valid store to word addr[31:2] on the acceptance edge; erroneous stores write nothing.
REQ-020 SHALL register resp_rdata on the edge entering RESP from the latched word index (load), else 0.
REQ-021 SHALL hold resp_valid, resp_rdata, resp_error stable in RESP until resp_valid & resp_ready at an edge, then go to IDLE.
REQ-022 SHALL keep req_ready=0 in the cycle resp is consumed (no same-cycle back-to-back); next acceptance is possible one edge later.
REQ-023 SHALL ignore req_* inputs outside IDLE.
REQ-024 SHALL read back data from a store accepted earlier, including a store accepted immediately before the load.

Reset
REQ-025 SHALL, on reset_n low, immediately enter IDLE with req_ready=0 while reset_n=0, then req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
REQ-026 SHALL abort any WAIT/RESP transaction on reset with no response produced; stores already committed at acceptance are retained.
REQ-027 SHALL NOT clear memory contents on reset (contents undefined until written).

Verification
REQ-028 Store 0xDEADBEEF at 0x10, then load 0x10 (LATENCY=2) -> load resp_valid 2 edges after acceptance, resp_rdata=0xDEADBEEF, resp_error=0.
REQ-029 Load at 0x13 -> resp_error=1, resp_rdata=0; store at 0x13 -> resp_error=1, following load of 0x10 unchanged.
REQ-030 Load at 0x400 with DEPTH_WORDS=256 -> resp_error=1, resp_rdata=0.
REQ-031 Hold resp_ready=0 for 5 cycles after resp_valid -> outputs stable, req_ready=0, second req_valid ignored; after consume, req_ready=1 next cycle.
REQ-032 Assert reset_n=0 one cycle after accepting a load -> resp_valid never rises, req_ready=1 after release, next transaction completes normally.
REQ-033 LATENCY=1 store 0x00000001 to 0x0 then load 0x0 -> each resp_valid one edge after acceptance, rdata=0x00000001.
